teclado_matricial: RTL and testbench

- Scans a 4x4 matrix keypad, debounces key presses and decodes them to 4-bit codes.
- Keeps a 20-digit history buffer and presents it as the packet consumed directly by `operacional`, over `digitos_value` and `digitos_valid`.
- Sits directly upstream of `operacional` and obeys its `teclado_en` gating.
- Runs on the system clock; the nominal rate is 1 kHz, so 1000 cycles = 1 s.

---
 rtl/teclado_matricial_pkg.sv | 60 ++++++
 rtl/teclado_matricial_if.sv | 14 +
 rtl/teclado_matricial_debounce.sv | 49 ++++
 rtl/teclado_matricial.sv | 167 ++++++++++++++++
 tb/tb_teclado_matricial.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/teclado_matricial_pkg.sv
// Shared types, key codes and key-map helpers for the matrix keypad front end.
package teclado_matricial_pkg;

   localparam int         N_DIGITS = 20;
   localparam logic [3:0] KEY_STAR = 4'hA;
   localparam logic [3:0] KEY_HASH = 4'hB;
   localparam logic [3:0] KEY_NONE = 4'hF;

   // Packet handed to the consumer: digits[0] is the newest, 0xF marks an empty slot.
   typedef struct packed {
      logic [N_DIGITS-1:0][3:0] digits;
   } senhaPac_t;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_EMIT     = 2'd2,
      ST_RELEASE  = 2'd3
   } kb_state_t;

   // (row, col) -> key code; the letter column decodes to KEY_NONE.
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      code = KEY_NONE;
      case ({row, col})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hC: code = KEY_STAR;
         4'hD: code = 4'h0;
         4'hE: code = KEY_HASH;
         default: code = KEY_NONE;
      endcase
      return code;
   endfunction

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & 4'(v - 4'd1)) == 4'b0000);
   endfunction

   // Index of the set bit of a one-hot nibble (0 when not one-hot).
   function automatic logic [1:0] onehot_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      case (v)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/teclado_matricial_if.sv
// Link between the keypad front end and its consumer.
// Handshake: digitos_valid is a single-cycle pulse with no backpressure; digitos_value
// carries the packet belonging to that pulse during the same cycle. teclado_en = 0 tells
// the keypad to ignore all key activity and hold an empty packet.
interface teclado_matricial_if;
   import teclado_matricial_pkg::*;

   logic      teclado_en;
   senhaPac_t digitos_value;
   logic      digitos_valid;

   modport master (input teclado_en, output digitos_value, output digitos_valid);
   modport slave  (output teclado_en, input digitos_value, input digitos_valid);
endinterface

// File: rtl/teclado_matricial_debounce.sv
// Column synchronizer plus a stability counter: counts consecutive cycles in which the
// synchronized columns equal a reference pattern (captured key for press, 0 for release).
module debounce_matricial #(
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_async_i,
   input  logic       cnt_clr_i,
   input  logic [3:0] ref_i,
   output logic [3:0] col_sync_o,
   output logic       match_o,
   output logic       stable_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [3:0]    sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // Two-flop synchronizer and stability counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 4'b0000;
         sync2_q <= 4'b0000;
         cnt_q   <= '0;
      end else begin
         sync1_q <= col_async_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
      end
   end

   // Count matching cycles; any mismatch restarts the run, saturating at the target.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr_i || !match_o) begin
         cnt_d = '0;
      end else if (cnt_q != CW'(DEBOUNCE_CYCLES)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign col_sync_o = sync2_q;
   assign match_o    = (sync2_q == ref_i);
   // High on the DEBOUNCE_CYCLES-th consecutive matching cycle.
   assign stable_o   = !cnt_clr_i && match_o && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/teclado_matricial.sv
// 4x4 keypad scanner: row scan FSM, key decode, 20-digit history buffer and idle timeout.
module teclado_matricial
   import teclado_matricial_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20,
   parameter int SCAN_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES  = 5000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            col_matricial,
   output logic [3:0]            lin_matricial,
   teclado_matricial_if.master   op_if,
   output kb_state_t             dbg_state_o
);

   localparam int SW = $clog2(SCAN_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   kb_state_t     state_q, state_d;
   logic [3:0]    row_q, row_d;
   logic [SW-1:0] scan_cnt_q, scan_cnt_d;
   logic [3:0]    cap_col_q, cap_col_d;
   senhaPac_t     buf_q, buf_d;
   logic          valid_q, valid_d;
   logic [TW-1:0] tmr_q, tmr_d;

   logic [3:0]    col_sync;
   logic          col_match;
   logic          col_stable;
   logic          cnt_clr;
   logic [3:0]    ref_pat;
   logic [3:0]    emit_code;
   logic          emit_ok;
   logic          en;

   assign en = op_if.teclado_en;

   debounce_matricial #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk         (clk),
      .rst         (rst),
      .col_async_i (col_matricial),
      .cnt_clr_i   (cnt_clr),
      .ref_i       (ref_pat),
      .col_sync_o  (col_sync),
      .match_o     (col_match),
      .stable_o    (col_stable)
   );

   // State, scan and buffer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_SCAN;
         row_q      <= 4'b0001;
         scan_cnt_q <= '0;
         cap_col_q  <= 4'b0000;
         buf_q      <= '1;
         valid_q    <= 1'b0;
         tmr_q      <= '0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         scan_cnt_q <= scan_cnt_d;
         cap_col_q  <= cap_col_d;
         buf_q      <= buf_d;
         valid_q    <= valid_d;
         tmr_q      <= tmr_d;
      end
   end

   // Scan FSM: rotate rows, lock onto a single pressed column, debounce, emit, await release.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      scan_cnt_d = scan_cnt_q;
      cap_col_d  = cap_col_q;
      cnt_clr    = 1'b0;
      ref_pat    = cap_col_q;
      emit_code  = KEY_NONE;
      emit_ok    = 1'b0;
      case (state_q)
         ST_SCAN: begin
            cnt_clr = 1'b1;
            if (scan_cnt_q == SW'(SCAN_CYCLES - 1)) begin
               scan_cnt_d = '0;
               if (is_onehot(col_sync)) begin
                  // Row stays frozen while the captured column is debounced.
                  state_d   = ST_DEBOUNCE;
                  cap_col_d = col_sync;
               end else begin
                  row_d = {row_q[2:0], row_q[3]};
               end
            end else begin
               scan_cnt_d = scan_cnt_q + SW'(1);
            end
         end
         ST_DEBOUNCE: begin
            if (!col_match) begin
               state_d    = ST_SCAN;
               scan_cnt_d = '0;
            end else if (col_stable) begin
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            cnt_clr   = 1'b1;
            emit_code = key_map(onehot_idx(row_q), onehot_idx(cap_col_q));
            emit_ok   = (emit_code != KEY_NONE);
            state_d   = ST_RELEASE;
         end
         ST_RELEASE: begin
            ref_pat = 4'b0000;
            if (col_stable) begin
               state_d    = ST_SCAN;
               scan_cnt_d = '0;
            end
         end
         default: begin
            state_d = ST_SCAN;
         end
      endcase
      // Disabled keypad: park the scanner so a held key must re-debounce after enable.
      if (!en) begin
         state_d    = ST_SCAN;
         row_d      = 4'b0001;
         scan_cnt_d = '0;
         cnt_clr    = 1'b1;
         emit_ok    = 1'b0;
      end
   end

   // History buffer: shift on emit, clear after a terminator, on idle timeout or when disabled.
   always_comb begin
      buf_d   = buf_q;
      valid_d = 1'b0;
      tmr_d   = '0;
      if (valid_q && ((buf_q.digits[0] == KEY_STAR) || (buf_q.digits[0] == KEY_HASH))) begin
         buf_d = '1;
      end
      if (buf_q.digits[0] != KEY_NONE) begin
         if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
            buf_d = '1;
         end else begin
            tmr_d = tmr_q + TW'(1);
         end
      end
      // An emit outranks a coincident timeout and restarts the idle timer.
      if (emit_ok) begin
         buf_d.digits = {buf_q.digits[N_DIGITS-2:0], emit_code};
         valid_d      = 1'b1;
         tmr_d        = '0;
      end
      if (!en) begin
         buf_d   = '1;
         valid_d = 1'b0;
         tmr_d   = '0;
      end
   end

   assign lin_matricial       = row_q;
   assign op_if.digitos_value = buf_q;
   assign op_if.digitos_valid = valid_q;
   assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_teclado_matricial.sv
// Directed bench for the keypad scanner: a keypad model drives the columns from the row
// drive, expected packets are queued at stimulus time and checked by a pulse monitor.
module tb_teclado_matricial;
  import teclado_matricial_pkg::*;

  localparam int HOLD = 60;
  localparam int REL  = 40;

  logic        clk;
  logic        rst;
  logic [3:0]  col_matricial;
  logic [3:0]  lin_matricial;
  kb_state_t   dbg_state;
  logic [15:0] key_mask;

  teclado_matricial_if kif ();

  teclado_matricial #(
    .DEBOUNCE_CYCLES(20),
    .SCAN_CYCLES(4),
    .TIMEOUT_CYCLES(5000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .col_matricial (col_matricial),
    .lin_matricial (lin_matricial),
    .op_if         (kif),
    .dbg_state_o   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key connects its row line to its column line.
  always_comb begin
    col_matricial = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      if (lin_matricial[r]) col_matricial = col_matricial | key_mask[r*4 +: 4];
    end
  end

  // Hand-written key table, index row*4+col.
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hF,
                            4'h4, 4'h5, 4'h6, 4'hF,
                            4'h7, 4'h8, 4'h9, 4'hF,
                            4'hA, 4'h0, 4'hB, 4'hF};

  logic [79:0] exp_q[$];
  logic [79:0] exp_buf;
  int          n_pass;
  int          n_total;
  logic        term_chk;

  localparam logic [79:0] ALL_F = {80{1'b1}};

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Scoreboard monitor: every pulse must match the next queued packet.
  initial begin
    term_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (term_chk) begin
        check("post_terminator_clear", kif.digitos_value, ALL_F);
        term_chk = 1'b0;
      end
      if (kif.digitos_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pulse actual=%h required=no pulse", kif.digitos_value);
        end else begin
          logic [79:0] e;
          e = exp_q.pop_front();
          check("pulse_packet", kif.digitos_value, e);
          if (e[3:0] == 4'hA || e[3:0] == 4'hB) term_chk = 1'b1;
        end
      end
    end
  end

  // Driver tasks
  task automatic push_key(input int r, input int c);
    logic [3:0] code;
    code = kmap[r*4+c];
    if (code != 4'hF) begin
      exp_buf = {exp_buf[75:0], code};
      exp_q.push_back(exp_buf);
      if (code == 4'hA || code == 4'hB) exp_buf = ALL_F;
    end
  endtask

  task automatic press(input int r, input int c, input int hold);
    push_key(r, c);
    key_mask = 16'h0;
    key_mask[r*4+c] = 1'b1;
    repeat (hold) @(negedge clk);
    key_mask = 16'h0;
    repeat (REL) @(negedge clk);
  endtask

  task automatic press_digit(input int d);
    if (d == 0) press(3, 1, HOLD);
    else press((d-1)/3, (d-1)%3, HOLD);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain_%s actual=%0d pending required=0 pending", name, exp_q.size());
  endtask

  // Stimulus
  initial begin
    int n;
    rst = 1'b1;
    key_mask = 16'h0;
    kif.teclado_en = 1'b1;
    exp_buf = ALL_F;
    n_pass = 0;
    n_total = 0;
    repeat (3) @(negedge clk);
    check("reset_value", kif.digitos_value, ALL_F);
    check("reset_valid", 80'(kif.digitos_valid), 80'd0);
    check("reset_lin", 80'(lin_matricial), 80'h1);
    check("reset_state", 80'(dbg_state), 80'(ST_SCAN));
    rst = 1'b0;

    // Single key '2'
    press(0, 1, HOLD);
    drain("key2");

    // 1, 2, 3, '*'
    press(0, 0, HOLD);
    press(0, 1, HOLD);
    press(0, 2, HOLD);
    press(3, 0, HOLD);
    drain("star_seq");
    check("after_star_empty", kif.digitos_value, ALL_F);

    // Bouncing '4' then a clean hold: one pulse
    push_key(1, 0);
    for (int i = 0; i < 12; i++) begin
      key_mask = (i % 2 == 0) ? 16'h0010 : 16'h0000;
      repeat (5) @(negedge clk);
    end
    key_mask = 16'h0010;
    repeat (HOLD) @(negedge clk);
    key_mask = 16'h0;
    repeat (REL) @(negedge clk);
    drain("bounce");

    // Long hold of '5': one pulse
    press(1, 1, 3000);
    drain("long_hold");

    // Two columns in one row, then letter 'D': no pulse, buffer unchanged
    key_mask = 16'h0050;
    repeat (HOLD) @(negedge clk);
    key_mask = 16'h0;
    repeat (REL) @(negedge clk);
    check("two_cols_unchanged", kif.digitos_value, exp_buf);
    press(3, 3, HOLD);
    check("letter_unchanged", kif.digitos_value, exp_buf);

    // '7' then idle: buffer empties after the timeout with no pulse
    push_key(2, 0);
    key_mask = 16'h0100;
    n = 0;
    while (kif.digitos_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n < 200) n_pass++;
    else $display("FAIL key7_pulse_wait actual=timeout required=pulse");
    n = 0;
    while (kif.digitos_value !== ALL_F && n < 6000) begin
      @(negedge clk);
      n++;
      if (n == HOLD) key_mask = 16'h0;
    end
    key_mask = 16'h0;
    n_total++;
    if (n >= 4998 && n <= 5002) n_pass++;
    else $display("FAIL timeout_clear actual=%0d cycles required=5000 cycles", n);
    exp_buf = ALL_F;
    drain("timeout");

    // 21 digits: oldest '0' drops out
    for (int i = 0; i < 21; i++) press_digit((i < 20) ? (i % 10) : 1);
    drain("overflow");
    check("overflow_buffer", kif.digitos_value, 80'h1234567890123456789_1);

    // Disabled while '8' held, then enabled with it still held
    kif.teclado_en = 1'b0;
    key_mask = 16'h0200;
    repeat (100) @(negedge clk);
    check("disabled_empty", kif.digitos_value, ALL_F);
    check("disabled_state", 80'(dbg_state), 80'(ST_SCAN));
    exp_buf = ALL_F;
    push_key(2, 1);
    kif.teclado_en = 1'b1;
    repeat (HOLD) @(negedge clk);
    key_mask = 16'h0;
    repeat (REL) @(negedge clk);
    drain("enable_held");

    // Reset in the middle of debouncing '9'
    key_mask = 16'h0400;
    n = 0;
    while (dbg_state !== ST_DEBOUNCE && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_value", kif.digitos_value, ALL_F);
    check("midrst_valid", 80'(kif.digitos_valid), 80'd0);
    check("midrst_lin", 80'(lin_matricial), 80'h1);
    check("midrst_state", 80'(dbg_state), 80'(ST_SCAN));
    rst = 1'b0;
    exp_buf = ALL_F;
    push_key(2, 2);
    repeat (HOLD) @(negedge clk);
    key_mask = 16'h0;
    repeat (REL) @(negedge clk);
    drain("reset_reaccept");

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
